// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard control bus: pipeline-stage observations in, stall/flush controls out.
// HAZARD_CTRL_STALL_CNT_EN adds the stall_cycles counter output.
interface pipe_hazard_ctrl_if;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned STALL_W = 16;

   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic [REG_W-1:0] ex_rt;
   logic             ex_mem_read;
   logic             branch_taken;
   logic             mdu_start;

   logic             pc_enable;
   logic             if_id_enable;
   logic             if_id_flush;
   logic             id_ex_enable;
   logic             id_ex_flush;
   logic             ex_mem_flush;
   logic             mdu_busy;
`ifdef HAZARD_CTRL_STALL_CNT_EN
   logic [STALL_W-1:0] stall_cycles;
`endif

   modport master (
      output id_rs, id_rt, ex_rt, ex_mem_read, branch_taken, mdu_start,
`ifdef HAZARD_CTRL_STALL_CNT_EN
      input  stall_cycles,
`endif
      input  pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
             ex_mem_flush, mdu_busy
   );

   modport slave (
      input  id_rs, id_rt, ex_rt, ex_mem_read, branch_taken, mdu_start,
`ifdef HAZARD_CTRL_STALL_CNT_EN
      output stall_cycles,
`endif
      output pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
             ex_mem_flush, mdu_busy
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / branch / multi-cycle MDU hazard controller for a 5-stage pipeline.
// Define HAZARD_CTRL_STALL_CNT_EN to add a saturating stall_cycles counter.
module pipe_hazard_ctrl #(
   parameter int unsigned MDU_LATENCY = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   pipe_hazard_ctrl_if.slave    hz
);
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned STALL_W = 16;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 1);

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MDU_WAIT = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
   logic             load_use_c;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_RUN;
         mdu_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         mdu_cnt_q <= mdu_cnt_d;
      end
   end

   assign load_use_c = hz.ex_mem_read && (hz.ex_rt != '0) &&
                       ((hz.ex_rt == hz.id_rs) || (hz.ex_rt == hz.id_rt));

   // Next state; the wait ends when the decremented count reaches zero
   always_comb begin
      state_d   = state_q;
      mdu_cnt_d = mdu_cnt_q;
      unique case (state_q)
         ST_RUN: begin
            if (hz.mdu_start && !load_use_c) begin
               state_d   = ST_MDU_WAIT;
               mdu_cnt_d = CNT_LOAD;
            end
         end
         ST_MDU_WAIT: begin
            mdu_cnt_d = (mdu_cnt_q == '0) ? '0 : mdu_cnt_q - CNT_W'(1);
            if (mdu_cnt_d == '0) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d   = ST_RUN;
            mdu_cnt_d = '0;
         end
      endcase
   end

   // Outputs, priority MDU wait > load-use > branch flush > normal
   always_comb begin
      hz.pc_enable    = 1'b1;
      hz.if_id_enable = 1'b1;
      hz.if_id_flush  = 1'b0;
      hz.id_ex_enable = 1'b1;
      hz.id_ex_flush  = 1'b0;
      hz.ex_mem_flush = 1'b0;
      hz.mdu_busy     = 1'b0;
      if (state_q == ST_MDU_WAIT) begin
         hz.pc_enable    = 1'b0;
         hz.if_id_enable = 1'b0;
         hz.id_ex_enable = 1'b0;
         hz.ex_mem_flush = 1'b1;
         hz.mdu_busy     = 1'b1;
      end else if (load_use_c) begin
         hz.pc_enable    = 1'b0;
         hz.if_id_enable = 1'b0;
         hz.id_ex_flush  = 1'b1;
      end else if (hz.branch_taken) begin
         hz.if_id_flush  = 1'b1;
      end
   end

`ifdef HAZARD_CTRL_STALL_CNT_EN
   logic [STALL_W-1:0] stall_cycles_q, stall_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (!hz.pc_enable && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + STALL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign hz.stall_cycles = stall_cycles_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios plus randomized traffic
// checked every cycle against a remaining-freeze-cycles reference model.
module tb_pipe_hazard_ctrl;
   localparam int unsigned LAT = 8;
   // Output vector: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush, busy}
   localparam logic [6:0] O_NORM = 7'b1101000;
   localparam logic [6:0] O_LU   = 7'b0001100;
   localparam logic [6:0] O_BR   = 7'b1111000;
   localparam logic [6:0] O_WAIT = 7'b0000011;

   logic clk = 1'b0;
   logic reset;

   pipe_hazard_ctrl_if hz ();

   pipe_hazard_ctrl #(.MDU_LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   always #5 clk = ~clk;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   int unsigned freeze_left = 0;
   int unsigned stall_m = 0;
   bit          model_valid = 1'b0;
   logic [6:0]  last_out;
   logic [15:0] last_stall;

   function automatic logic [6:0] dut_out();
      return {hz.pc_enable, hz.if_id_enable, hz.if_id_flush, hz.id_ex_enable,
              hz.id_ex_flush, hz.ex_mem_flush, hz.mdu_busy};
   endfunction

   function automatic logic is_lu(input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] exrt, input logic mr);
      return mr && (exrt != 5'd0) && (exrt == rs || exrt == rt);
   endfunction

   function automatic logic [6:0] model_out(input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] exrt, input logic mr,
                                            input logic br);
      if (freeze_left > 0)          return O_WAIT;
      if (is_lu(rs, rt, exrt, mr))  return O_LU;
      if (br)                       return O_BR;
      return O_NORM;
   endfunction

   task automatic check7(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // One clock cycle: drive, compare mid-cycle, then advance the model at the edge
   task automatic do_cycle(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] exrt, input logic mr, input logic br,
                           input logic ms);
      logic [6:0] exp;
      reset           = rst;
      hz.id_rs        = rs;
      hz.id_rt        = rt;
      hz.ex_rt        = exrt;
      hz.ex_mem_read  = mr;
      hz.branch_taken = br;
      hz.mdu_start    = ms;
      #3;
      last_out = dut_out();
      exp      = model_out(rs, rt, exrt, mr, br);
      if (model_valid) check7("outputs", last_out, exp);
`ifdef HAZARD_CTRL_STALL_CNT_EN
      last_stall = hz.stall_cycles;
      if (model_valid) check_int("stall_cycles", int'(last_stall), int'(stall_m));
`else
      last_stall = 16'd0;
`endif
      @(posedge clk);
      if (!rst) begin
         freeze_left = 0;
         stall_m     = 0;
         model_valid = 1'b1;
      end else if (model_valid) begin
         if (!exp[6] && stall_m < 65535) stall_m++;
         if (freeze_left > 0) freeze_left--;
         else if (ms && !is_lu(rs, rt, exrt, mr)) freeze_left = LAT - 1;
      end
      #1;
   endtask

   task automatic idle();
      do_cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int busy_n;
      int pcl_n;
      do_cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      do_cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      idle();
      check7("reset_out", last_out, O_NORM);

      do_cycle(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
      check7("load_use_rs", last_out, O_LU);
      do_cycle(1'b1, 5'd3, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
      check7("after_bubble", last_out, O_NORM);
      do_cycle(1'b1, 5'd7, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0);
      check7("load_use_rt", last_out, O_LU);
      do_cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      check7("lu_r0_no_stall", last_out, O_NORM);

      do_cycle(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
      check7("branch", last_out, O_BR);
      idle();
      check7("after_branch", last_out, O_NORM);

      do_cycle(1'b1, 5'd4, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
      check7("lu_plus_branch", last_out, O_LU);
      do_cycle(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      check7("branch_reeval", last_out, O_BR);

      do_cycle(1'b1, 5'd6, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1);
      check7("lu_plus_mdu", last_out, O_LU);
      idle();
      check7("lu_mdu_stays_run", last_out, O_NORM);

      // MDU op: count frozen cycles while garbage branch/start/hazard is ignored
      do_cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      check7("mdu_start_cycle", last_out, O_NORM);
      busy_n = 0;
      pcl_n  = 0;
      for (int i = 0; i < 12; i++) begin
         do_cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
         busy_n += int'(last_out[0]);
         pcl_n  += int'(!last_out[6]);
         if (i == 0) check7("mdu_wait_out", last_out, O_WAIT);
      end
      check_int("mdu_busy_cycles", busy_n, 7);
      check_int("mdu_pc_low_cycles", pcl_n, 7);
      check7("after_mdu", last_out, O_BR);

      // Reset on the third wait cycle aborts the wait
      do_cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      do_cycle(1'b1, 5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1);
      idle();
      do_cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check7("wait3_under_reset", last_out, O_WAIT);
      idle();
      check7("after_reset_mid_wait", last_out, O_NORM);

      for (int i = 0; i < 3000; i++) begin
         do_cycle(logic'($urandom_range(0, 199) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), logic'($urandom_range(0, 2) == 0),
                  logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 9) == 0));
      end

`ifdef HAZARD_CTRL_STALL_CNT_EN
      do_cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      idle();
      check_int("stall_after_reset", int'(last_stall), 0);
      do_cycle(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
      do_cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) idle();
      check_int("stall_lu_plus_mdu", int'(last_stall), 8);
      for (int i = 0; i < 65540; i++) do_cycle(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
      idle();
      check_int("stall_saturate", int'(last_stall), 65535);
      do_cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      idle();
      check_int("stall_cleared", int'(last_stall), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
